// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state (IDLE/READ/EXEC/WB) sequencer that issues one
// 4-bit ALU instruction at a time against an external 16x4 register file.
// The instruction is latched on acceptance. Operands are captured at the end of
// READ. The 5-bit result is registered at the end of EXEC. The write-back and
// the status flags take effect on the edge that ends WB.
module alu_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [3:0]  rf_raddr1,
    output logic [3:0]  rf_raddr2,
    input  logic [3:0]  rf_rdata1,
    input  logic [3:0]  rf_rdata2,
    output logic [3:0]  rf_waddr,
    output logic [3:0]  rf_wdata,
    output logic        rf_w_en,
    output logic        carry,
    output logic        zero,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [3:0]  op1_q, op1_d;
    logic [3:0]  op2_q, op2_d;
    logic [4:0]  result_q, result_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;

    logic        accept;
    logic [3:0]  opcode;
    logic [3:0]  rd_field;
    logic [3:0]  rs1_field;
    logic [3:0]  rs2_field;

    // Result bit 4 carries the flag-relevant bit out of each operation:
    // the carry for ADD/ADDI, the borrow for SUB, the bit shifted out for
    // SHL/SHR, and 0 for logical ops, LDI and MOV.
    function automatic logic [4:0] alu_compute(
        input logic [3:0] op,
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [3:0] imm
    );
        logic [4:0] r;
        r = 5'd0;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_LDI:  r = {1'b0, imm};
            OP_MOV:  r = {1'b0, a};
            OP_SHL:  r = {a, 1'b0};
            OP_SHR:  r = {a[0], 1'b0, a[3:1]};
            OP_ADDI: r = {1'b0, a} + {1'b0, imm};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    // Opcodes 1..A write a result and update zero.
    function automatic logic writes_rf(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_ADDI);
    endfunction

    // LDI and MOV leave carry alone; every other writing opcode updates it.
    function automatic logic updates_carry(input logic [3:0] op);
        return writes_rf(op) && (op != OP_LDI) && (op != OP_MOV);
    endfunction

    // Opcodes B..F are not defined.
    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_ADDI;
    endfunction

    assign opcode    = instr_q[15:12];
    assign rd_field  = instr_q[11:8];
    assign rs1_field = instr_q[7:4];
    assign rs2_field = instr_q[3:0];

    assign accept    = instr_valid && (state_q == IDLE);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only IDLE waits; the rest of the sequence is fixed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: handshake, register-file controls and retire pulses.
    always_comb begin
        instr_ready = 1'b0;
        rf_w_en     = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            IDLE: instr_ready = 1'b1;
            WB: begin
                rf_w_en = writes_rf(opcode);
                done    = 1'b1;
                err     = is_illegal(opcode);
            end
            default: ;
        endcase
    end

    assign rf_raddr1 = rs1_field;
    assign rf_raddr2 = rs2_field;
    assign rf_waddr  = rd_field;
    assign rf_wdata  = result_q[3:0];
    assign carry     = carry_q;
    assign zero      = zero_q;

    // Datapath next-state: the latch, capture and execute steps each happen in one state only.
    always_comb begin
        instr_d  = instr_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;
        if (accept) begin
            instr_d = instr;
        end
        if (state_q == READ) begin
            op1_d = rf_rdata1;
            op2_d = rf_rdata2;
        end
        if (state_q == EXEC) begin
            result_d = alu_compute(opcode, op1_q, op2_q, rs2_field);
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q  <= 16'd0;
            op1_q    <= 4'd0;
            op2_q    <= 4'd0;
            result_q <= 5'd0;
        end else begin
            instr_q  <= instr_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
        end
    end

    // Flag next-state: flags change only on the edge that ends WB.
    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (state_q == WB) begin
            if (updates_carry(opcode)) begin
                carry_d = result_q[4];
            end
            if (writes_rf(opcode)) begin
                zero_d = (result_q[3:0] == 4'd0);
            end
        end
    end

    // Status flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors for alu_sequencer with a behavioural
// 16x4 register file. Inputs are driven and outputs sampled on the falling edge.
module tb_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [3:0]  rf_rdata1;
    logic [3:0]  rf_rdata2;
    logic [3:0]  rf_waddr;
    logic [3:0]  rf_wdata;
    logic        rf_w_en;
    logic        carry;
    logic        zero;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    alu_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_w_en     (rf_w_en),
        .carry       (carry),
        .zero        (zero),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    // Behavioural register file: combinational read, write on the rising edge.
    logic [3:0] rf [16] = '{default: 4'h0};
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];
    always @(posedge clock) begin
        if (rf_w_en) rf[rf_waddr] <= rf_wdata;
    end

    // Edge monitors: cycle count, acceptance cycles, write-enable pulses.
    int cyc = 0;
    int acc_q[$];
    int wen_cnt = 0;
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset_n && instr_valid && instr_ready) acc_q.push_back(cyc);
        if (rf_w_en) wen_cnt = wen_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with the sequencer in IDLE. Returns
    // just after the falling edge following WB (IDLE again).
    task automatic exec_instr(input string tag, input logic [15:0] ins, input logic exp_wen,
                              input logic [3:0] exp_waddr, input logic [3:0] exp_wdata,
                              input logic exp_err);
        instr_valid = 1'b1;
        instr       = ins;
        check({tag, "_idle_ready"}, 32'(instr_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
        check({tag, "_rd_ready"}, 32'(instr_ready), 32'd0);
        check({tag, "_raddr1"}, 32'(rf_raddr1), 32'(ins[7:4]));
        check({tag, "_raddr2"}, 32'(rf_raddr2), 32'(ins[3:0]));
        check({tag, "_rd_wen"}, 32'(rf_w_en), 32'd0);
        check({tag, "_rd_done"}, 32'(done), 32'd0);
        @(negedge clock);
        check({tag, "_ex_wen"}, 32'(rf_w_en), 32'd0);
        check({tag, "_ex_done"}, 32'(done), 32'd0);
        @(negedge clock);
        check({tag, "_wb_wen"}, 32'(rf_w_en), 32'(exp_wen));
        check({tag, "_wb_done"}, 32'(done), 32'd1);
        check({tag, "_wb_err"}, 32'(err), 32'(exp_err));
        check({tag, "_wb_ready"}, 32'(instr_ready), 32'd0);
        if (exp_wen) begin
            check({tag, "_waddr"}, 32'(rf_waddr), 32'(exp_waddr));
            check({tag, "_wdata"}, 32'(rf_wdata), 32'(exp_wdata));
        end
        @(negedge clock);
        check({tag, "_post_done"}, 32'(done), 32'd0);
        check({tag, "_post_err"}, 32'(err), 32'd0);
        check({tag, "_post_ready"}, 32'(instr_ready), 32'd1);
    endtask

    task automatic check_flags(input string tag, input logic exp_c, input logic exp_z);
        check({tag, "_carry"}, 32'(carry), 32'(exp_c));
        check({tag, "_zero"}, 32'(zero), 32'(exp_z));
    endtask

    initial begin
        int base;
        int wen_snap;

        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        #12;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_wen", 32'(rf_w_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check_flags("rst", 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic arithmetic and flags.
        exec_instr("ldi_r1", 16'h6109, 1'b1, 4'd1, 4'h9, 1'b0);
        check_flags("ldi_r1", 1'b0, 1'b0);
        exec_instr("ldi_r2", 16'h6208, 1'b1, 4'd2, 4'h8, 1'b0);
        exec_instr("add_r3", 16'h1312, 1'b1, 4'd3, 4'h1, 1'b0);
        check_flags("add_r3", 1'b1, 1'b0);
        exec_instr("ill_f", 16'hF000, 1'b0, 4'd0, 4'h0, 1'b1);
        check_flags("ill_f", 1'b1, 1'b0);
        exec_instr("sub_r4", 16'h2421, 1'b1, 4'd4, 4'hF, 1'b0);
        check_flags("sub_r4", 1'b1, 1'b0);
        exec_instr("xor_r11", 16'h5B11, 1'b1, 4'd11, 4'h0, 1'b0);
        check_flags("xor_r11", 1'b0, 1'b1);
        exec_instr("addi_r12", 16'hAC17, 1'b1, 4'd12, 4'h0, 1'b0);
        check_flags("addi_r12", 1'b1, 1'b1);
        exec_instr("sub_r5", 16'h2511, 1'b1, 4'd5, 4'h0, 1'b0);
        check_flags("sub_r5", 1'b0, 1'b1);
        exec_instr("nop", 16'h0000, 1'b0, 4'd0, 4'h0, 1'b0);
        check_flags("nop", 1'b0, 1'b1);
        exec_instr("or_r13", 16'h4D12, 1'b1, 4'd13, 4'h9, 1'b0);
        check_flags("or_r13", 1'b0, 1'b0);
        exec_instr("and_r10", 16'h3A12, 1'b1, 4'd10, 4'h8, 1'b0);
        exec_instr("mov_r14", 16'h7E20, 1'b1, 4'd14, 4'h8, 1'b0);
        check_flags("mov_r14", 1'b0, 1'b0);

        // instr_valid held high: LDI r6,5 then ADD r7,r6,r6.
        base        = acc_q.size();
        instr_valid = 1'b1;
        instr       = 16'h6605;
        check("raw_idle_ready", 32'(instr_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        instr = 16'h1766;
        for (int i = 1; i <= 3; i++) begin
            check("raw_busy_ready", 32'(instr_ready), 32'd0);
            if (i == 3) begin
                check("raw_ldi_wen", 32'(rf_w_en), 32'd1);
                check("raw_ldi_waddr", 32'(rf_waddr), 32'd6);
                check("raw_ldi_wdata", 32'(rf_wdata), 32'h5);
            end
            @(negedge clock);
        end
        check("raw_idle2_ready", 32'(instr_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        check("raw_rd2_ready", 32'(instr_ready), 32'd0);
        @(negedge clock);
        @(negedge clock);
        check("raw_add_wen", 32'(rf_w_en), 32'd1);
        check("raw_add_waddr", 32'(rf_waddr), 32'd7);
        check("raw_add_wdata", 32'(rf_wdata), 32'hA);
        check("raw_add_done", 32'(done), 32'd1);
        @(negedge clock);
        check_flags("raw_add", 1'b0, 1'b0);
        check("raw_acc_count", 32'(acc_q.size() - base), 32'd2);
        if (acc_q.size() - base >= 2)
            check("raw_acc_gap", 32'(acc_q[base + 1] - acc_q[base]), 32'd4);

        // Shifts.
        exec_instr("shr_r9", 16'h9910, 1'b1, 4'd9, 4'h4, 1'b0);
        check_flags("shr_r9", 1'b1, 1'b0);
        exec_instr("shl_r9", 16'h8990, 1'b1, 4'd9, 4'h8, 1'b0);
        check_flags("shl_r9", 1'b0, 1'b0);

        // Set carry, preload r8, then reset during EXEC of ADD r8,r1,r2.
        exec_instr("addi_r10", 16'hAA1F, 1'b1, 4'd10, 4'h8, 1'b0);
        exec_instr("ldi_r8", 16'h6803, 1'b1, 4'd8, 4'h3, 1'b0);
        check_flags("ldi_r8", 1'b1, 1'b0);
        wen_snap    = wen_cnt;
        instr_valid = 1'b1;
        instr       = 16'h1812;
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(instr_ready), 32'd1);
        check("mid_rst_wen", 32'(rf_w_en), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check_flags("mid_rst", 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check("mid_rst_no_wen", 32'(wen_cnt - wen_snap), 32'd0);
        check("mid_rst_r8", 32'(rf[8]), 32'h3);
        reset_n = 1'b1;
        check("rel_ready", 32'(instr_ready), 32'd1);
        exec_instr("ldi_r15", 16'h6F07, 1'b1, 4'd15, 4'h7, 1'b0);
        check("ldi_r15_rf", 32'(rf[15]), 32'h7);
        check("r8_kept", 32'(rf[8]), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 No parameters; all widths are fixed by the 16x4 register file the block drives.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 instr_valid  input  1  upstream instruction valid.
REQ-005 instr  input  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2 or imm.
REQ-006 instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 rf_raddr1, rf_raddr2  output  4 each  register-file read addresses (rs1, rs2).
REQ-008 rf_rdata1, rf_rdata2  input  4 each  combinational register-file read data.
REQ-009 rf_waddr  output  4  register-file write address.
REQ-010 rf_wdata  output  4  register-file write data.
REQ-011 rf_w_en  output  1  register-file write enable; the file writes on the clock edge that ends the cycle.
REQ-012 carry, zero  output  1 each  registered status flags.
REQ-013 done  output  1  one-cycle pulse when an instruction retires.
REQ-014 err  output  1  one-cycle pulse, coincident with done, for an illegal opcode.

Function
REQ-015 FSM states: IDLE, READ, EXEC, WB.
REQ-016 Transitions: IDLE->READ on instr_valid&instr_ready; READ->EXEC, EXEC->WB and WB->IDLE unconditionally.
REQ-017 instr_ready=1 only in IDLE; on acceptance, instr is latched and upstream may change it afterwards.
REQ-018 rf_raddr1/rf_raddr2 are driven from the latched rs1/rs2 fields.
REQ-019 Operands are captured from rf_rdata1/rf_rdata2 at the end of READ.
REQ-020 EXEC computes a 5-bit result into a register; rf_wdata is the low 4 bits, and rf_waddr is the latched rd.
REQ-021 Opcodes (all arithmetic modulo 16):
- 0 NOP; 1 ADD rs1+rs2; 2 SUB rs1-rs2; 3 AND; 4 OR; 5 XOR;
- 6 LDI rd=imm; 7 MOV rd=rs1; 8 SHL rs1<<1; 9 SHR rs1>>1 (logical); A ADDI rs1+imm;
- B-F illegal.
REQ-022 rf_w_en=1 for exactly the WB cycle for opcodes 1-A; it is 0 in all other states and for NOP or illegal opcodes.
REQ-023 done pulses in WB for every accepted instruction; err also pulses in WB for opcodes B-F.
REQ-024 Latency: with acceptance at cycle N, WB (w_en, done) is at N+3, and the next acceptance is possible at N+4 earliest.
REQ-025 Read-after-write: an instruction accepted at N+4 or later reads the value written at N+3; no forwarding is required.
REQ-026 carry, zero update at the WB edge only, as follows:
- carry: ADD/ADDI sum bit 4; SUB borrow (rs1<rs2); SHL old bit 3; SHR old bit 0; AND/OR/XOR clear carry.
- zero: result==0 for opcodes 1-A.
- LDI/MOV update zero only.
- NOP and illegal opcodes leave both flags unchanged.
REQ-027 rd may equal rs1 or rs2; operands are already captured, so the result is correct.
REQ-028 instr_valid held high across a busy period causes no duplicate acceptance; acceptance occurs only in IDLE.

Reset
REQ-029 reset_n low forces, immediately and independently of clock:
- state=IDLE;
- latched instruction, operands, result = 0;
- rf_w_en, done, err, carry, zero = 0.
REQ-030 instr_ready=1 during and after reset, since the FSM is in IDLE.
REQ-031 Reset mid-instruction drops the instruction: no rf_w_en pulse, no done; the register file contents are untouched by this block.
REQ-032 The first acceptance is possible on the first rising edge after reset_n rises.

Verification
REQ-033 LDI r1,9; LDI r2,8; ADD r3,r1,r2 -> WB: waddr=3, wdata=1, carry=1, zero=0; done pulses once per instruction.
REQ-034 SUB r4,r2,r1 -> wdata=F, carry=1; then SUB r5,r1,r1 -> wdata=0, carry=0, zero=1.
REQ-035 instr_valid held high with LDI r6,5 then ADD r7,r6,r6:
- acceptances exactly 4 cycles apart;
- second instruction writes r7=A, carry=0 (RAW correct);
- instr_ready low in READ/EXEC/WB.
REQ-036 Opcode F issued -> rf_w_en stays 0; done=err=1 for one cycle; carry/zero unchanged.
REQ-037 reset_n pulsed low during EXEC of ADD r8,r1,r2 -> rf_w_en never asserts; readback of r8 is unchanged; instr_ready=1 after release.
REQ-038 r1=9, SHR r9,r1 -> wdata=4, carry=1; then SHL r9,r9 -> wdata=8, carry=0.
